// File: rtl/regfile_scoreboard_if.sv
// Issue/write-back bundle between IDU, WBU and the register file scoreboard.
// master = pipeline side driving requests, slave = register file.
interface regfile_scoreboard_if #(
  parameter int XLEN = 32
);
  logic            iss_valid;
  logic            iss_wen;
  logic [4:0]      iss_rd;
  logic [4:0]      iss_rs1;
  logic [4:0]      iss_rs2;
  logic            iss_ready;
  logic [XLEN-1:0] iss_rdata1;
  logic [XLEN-1:0] iss_rdata2;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            sb_busy;

  modport master (
    output iss_valid, iss_wen, iss_rd, iss_rs1, iss_rs2,
    output wb_valid, wb_rd, wb_data, flush,
    input  iss_ready, iss_rdata1, iss_rdata2, sb_busy
  );

  modport slave (
    input  iss_valid, iss_wen, iss_rd, iss_rs1, iss_rs2,
    input  wb_valid, wb_rd, wb_data, flush,
    output iss_ready, iss_rdata1, iss_rdata2, sb_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register pending-write counters and decode stall.
// Optional same-cycle forwarding of write-back data to the read ports.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 16,
  parameter int PCNT_W = 2,
  parameter int BYPASS = 1
) (
  input logic                 clock,
  input logic                 reset,
  regfile_scoreboard_if.slave bus
);
  localparam int IDX_W = $clog2(NREG);
  localparam logic [PCNT_W-1:0] PCNT_MAX = '1;
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

  logic [XLEN-1:0]   rf       [NREG];
  logic [PCNT_W-1:0] pcnt     [NREG];
  logic [PCNT_W-1:0] pcnt_nxt [NREG];
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;
  logic [NREG-1:0]   wb_we;

  logic [IDX_W-1:0] rd_idx, rs1_idx, rs2_idx, wb_idx;
  logic wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
  logic haz_rs1, haz_rs2, haz_cap, fire;

  assign rd_idx  = bus.iss_rd[IDX_W-1:0];
  assign rs1_idx = bus.iss_rs1[IDX_W-1:0];
  assign rs2_idx = bus.iss_rs2[IDX_W-1:0];
  assign wb_idx  = bus.wb_rd[IDX_W-1:0];

  // Upper address bits are don't-care when fewer than 32 registers exist.
  if (IDX_W < 5) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.iss_rd[4:IDX_W], bus.iss_rs1[4:IDX_W],
                              bus.iss_rs2[4:IDX_W], bus.wb_rd[4:IDX_W]};
  end

  assign wb_hit_rs1 = bus.wb_valid && (wb_idx == rs1_idx) && (rs1_idx != '0);
  assign wb_hit_rs2 = bus.wb_valid && (wb_idx == rs2_idx) && (rs2_idx != '0);
  assign wb_hit_rd  = bus.wb_valid && (wb_idx == rd_idx);

  // With forwarding, the last outstanding writer completing now resolves the hazard.
  assign haz_rs1 = (rs1_idx != '0) && (pcnt[rs1_idx] != '0) &&
                   !((BYPASS != 0) && wb_hit_rs1 && (pcnt[rs1_idx] == PCNT_ONE));
  assign haz_rs2 = (rs2_idx != '0) && (pcnt[rs2_idx] != '0) &&
                   !((BYPASS != 0) && wb_hit_rs2 && (pcnt[rs2_idx] == PCNT_ONE));
  assign haz_cap = bus.iss_wen && (rd_idx != '0) && (pcnt[rd_idx] == PCNT_MAX) && !wb_hit_rd;

  assign bus.iss_ready = reset && !bus.flush && !haz_rs1 && !haz_rs2 && !haz_cap;
  assign fire          = bus.iss_valid && bus.iss_ready;

  assign bus.iss_rdata1 = (rs1_idx == '0) ? '0 :
                          ((BYPASS != 0) && wb_hit_rs1) ? bus.wb_data : rf[rs1_idx];
  assign bus.iss_rdata2 = (rs2_idx == '0) ? '0 :
                          ((BYPASS != 0) && wb_hit_rs2) ? bus.wb_data : rf[rs2_idx];

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    wb_we   = '0;
    for (int i = 1; i < NREG; i++) begin
      wb_we[i]   = bus.wb_valid && (wb_idx == IDX_W'(i));
      inc_vec[i] = fire && bus.iss_wen && (rd_idx == IDX_W'(i));
      dec_vec[i] = wb_we[i] && (pcnt[i] != '0);
    end
  end

  // Flush overrides both increment and decrement; dec at zero never reaches here.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      pcnt_nxt[i] = pcnt[i];
      if (bus.flush)
        pcnt_nxt[i] = '0;
      else if (inc_vec[i] && !dec_vec[i])
        pcnt_nxt[i] = pcnt[i] + PCNT_ONE;
      else if (dec_vec[i] && !inc_vec[i])
        pcnt_nxt[i] = pcnt[i] - PCNT_ONE;
    end
  end

  always_comb begin
    bus.sb_busy = 1'b0;
    for (int i = 0; i < NREG; i++)
      bus.sb_busy = bus.sb_busy | (pcnt[i] != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i]   <= '0;
        pcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_we[i])
          rf[i] <= bus.wb_data;
        pcnt[i] <= pcnt_nxt[i];
      end
    end
  end
endmodule
